// File: rtl/gpio_link_pkg.sv
// Shared types and default sizing for the GPIO word-link engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package gpio_link_pkg;

   localparam int DEF_DATA_WIDTH  = 15;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_HOLD_CYCLES = 4;
   localparam int DEF_TURN_CYCLES = 2;

   typedef enum logic [1:0] {
      LS_RX   = 2'd0,
      LS_TURN = 2'd1,
      LS_TX   = 2'd2
   } link_state_t;

endpackage

// File: rtl/gpio_link_rx_fifo.sv
// Synchronous FIFO holding received payloads, head word kept in a register.
// Latency: push -> head_vld one cycle; pop advances head on the same edge.
// Backpressure: push is accepted when not full, or when full with a pop in the same cycle.
//
// Ports: clk/rst (sync, active-high); push_vld/push_dat write side;
//        pop_rdy read side; head_dat/head_vld current head; full status.
module gpio_link_rx_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             head_vld,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic [AW-1:0]    w_rd_next;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_pop     = pop_rdy && !w_empty;
   assign w_push    = push_vld && (!w_full || w_pop);
   assign w_rd_next = r_rd_ptr + AW'(1);

   assign head_dat = r_head;
   assign head_vld = !w_empty;
   assign full     = w_full;

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
         // Head follows the entry that will be at the read pointer after this edge.
         // With two or more entries the successor is already in storage; with one,
         // only a simultaneous push can supply the new head.
         if (w_pop) begin
            if (r_count >= (AW+1)'(2)) begin
               r_head <= r_mem[w_rd_next];
            end else if (w_push) begin
               r_head <= push_dat;
            end
         end else if (w_push && w_empty) begin
            r_head <= push_dat;
         end
      end
   end

endmodule

// File: rtl/gpio_link_ctrl.sv
// Half-duplex toggle-framed word link between the GPIO pad bus and core streams.
// Latency: tx accept -> pad_a 1 cycle; pad_y change -> rx_valid 4 cycles minimum.
// Backpressure: tx_ready low during hold/turnaround/RX; RX words dropped (sticky flag) when FIFO full.
//
// Ports: clk, rst (sync, active-high); dir_in direction from control pad (async);
//        pad_a/pad_y pad bus; tx_data/tx_valid/tx_ready core TX stream;
//        rx_data/rx_valid/rx_ready core RX stream; rx_overflow sticky drop flag;
//        link_state 0=RX, 1=TURN, 2=TX.
module gpio_link_ctrl
   import gpio_link_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dir_in,
   output logic [DATA_WIDTH-1:0] pad_a,
   input  logic [DATA_WIDTH-1:0] pad_y,
   input  logic [DATA_WIDTH-2:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-2:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_overflow,
   output logic [1:0]            link_state
);

   localparam int MSB = DATA_WIDTH - 1;
   localparam int HW  = $clog2(HOLD_CYCLES + 1);
   localparam int TW  = $clog2(TURN_CYCLES + 1);

   logic                  r_dir_s1;
   logic                  r_dir_s;
   logic [DATA_WIDTH-1:0] r_y_s1;
   logic [DATA_WIDTH-1:0] r_y_s;
   logic [DATA_WIDTH-1:0] r_y_d;

   link_state_t           r_state;
   logic [TW-1:0]         r_turn_cnt;
   logic                  r_turn_dir;   // direction the current turnaround is heading to
   logic [HW-1:0]         r_hold_cnt;
   logic                  r_tx_toggle;
   logic [DATA_WIDTH-1:0] r_pad_a;
   logic                  r_rx_last_toggle;
   logic                  r_rx_overflow;

   logic                  w_tx_rdy;
   logic                  w_tx_acc;
   logic                  w_rx_det;
   logic                  w_fifo_full;
   logic                  w_drop;

   assign w_tx_rdy = (r_state == LS_TX) && (r_hold_cnt == '0);
   assign w_tx_acc = w_tx_rdy && tx_valid;

   // A new word is a bus value stable for two samples whose toggle differs from the last one taken.
   assign w_rx_det = (r_state == LS_RX) && (r_y_s == r_y_d) && (r_y_s[MSB] != r_rx_last_toggle);

   // A pop frees the slot in the same cycle, so only a push without pop is lost when full.
   assign w_drop = w_rx_det && w_fifo_full && !rx_ready;

   assign pad_a       = r_pad_a;
   assign tx_ready    = w_tx_rdy;
   assign rx_overflow = r_rx_overflow;
   assign link_state  = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dir_s1         <= 1'b0;
         r_dir_s          <= 1'b0;
         r_y_s1           <= '0;
         r_y_s            <= '0;
         r_y_d            <= '0;
         r_state          <= LS_RX;
         r_turn_cnt       <= '0;
         r_turn_dir       <= 1'b0;
         r_hold_cnt       <= '0;
         r_tx_toggle      <= 1'b0;
         r_pad_a          <= '0;
         r_rx_last_toggle <= 1'b0;
         r_rx_overflow    <= 1'b0;
      end else begin
         r_dir_s1 <= dir_in;
         r_dir_s  <= r_dir_s1;
         r_y_s1   <= pad_y;
         r_y_s    <= r_y_s1;
         r_y_d    <= r_y_s;

         case (r_state)
            LS_RX: begin
               if (r_dir_s) begin
                  r_state    <= LS_TURN;
                  r_turn_cnt <= '0;
                  r_turn_dir <= 1'b1;
               end
            end
            LS_TX: begin
               if (w_tx_acc) begin
                  r_pad_a     <= {~r_tx_toggle, tx_data};
                  r_tx_toggle <= ~r_tx_toggle;
                  r_hold_cnt  <= HW'(HOLD_CYCLES);
               end else if (r_hold_cnt != '0) begin
                  r_hold_cnt <= r_hold_cnt - HW'(1);
               end
               if (!r_dir_s) begin
                  r_state    <= LS_TURN;
                  r_turn_cnt <= '0;
                  r_turn_dir <= 1'b0;
               end
            end
            LS_TURN: begin
               r_hold_cnt <= '0;
               if (r_dir_s != r_turn_dir) begin
                  r_turn_cnt <= '0;
                  r_turn_dir <= r_dir_s;
               end else if (r_turn_cnt == TW'(TURN_CYCLES - 1)) begin
                  if (r_dir_s) begin
                     r_state <= LS_TX;
                  end else begin
                     r_state          <= LS_RX;
                     // Whatever is on the bus now is stale; only a later toggle counts.
                     r_rx_last_toggle <= r_y_s[MSB];
                  end
               end else begin
                  r_turn_cnt <= r_turn_cnt + TW'(1);
               end
            end
            default: r_state <= LS_RX;
         endcase

         if (w_rx_det) begin
            r_rx_last_toggle <= r_y_s[MSB];
         end
         if (w_drop) begin
            r_rx_overflow <= 1'b1;
         end
      end
   end

   gpio_link_rx_fifo #(
      .WIDTH (DATA_WIDTH - 1),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (w_rx_det),
      .push_dat (r_y_s[DATA_WIDTH-2:0]),
      .pop_rdy  (rx_ready),
      .head_dat (rx_data),
      .head_vld (rx_valid),
      .full     (w_fifo_full)
   );

endmodule

// File: tb/tb_gpio_link_ctrl.sv
// Self-checking bench for gpio_link_ctrl: TX table plus hand sequences for RX, turnaround, overflow, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_link_ctrl;

   logic        clk;
   logic        rst;
   logic        dir_in;
   logic [14:0] pad_a;
   logic [14:0] pad_y;
   logic [13:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [13:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_overflow;
   logic [1:0]  link_state;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic        dir;
      logic        vld;
      logic [13:0] dat;
      logic [1:0]  st;
      logic        rdy;
      logic [14:0] pad;
   } vec_t;

   vec_t tbl [12];

   gpio_link_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .dir_in      (dir_in),
      .pad_a       (pad_a),
      .pad_y       (pad_y),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_overflow (rx_overflow),
      .link_state  (link_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [1:0] exp, input string name);
      for (int i = 0; i < 20; i++) begin
         if (link_state == exp) break;
         step();
      end
      check(name, 32'(link_state), 32'(exp));
   endtask

   task automatic wait_rdy(input string name);
      for (int i = 0; i < 20; i++) begin
         if (tx_ready) break;
         step();
      end
      check(name, 32'(tx_ready), 32'd1);
   endtask

   task automatic hold_bus(input logic [14:0] val, input int n);
      pad_y = val;
      repeat (n) step();
   endtask

   task automatic pop_check(input logic [13:0] exp);
      check("pop_valid", 32'(rx_valid), 32'd1);
      check("pop_data", 32'(rx_data), 32'(exp));
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
   endtask

   initial begin
      //            dir   vld   dat        st    rdy   pad
      tbl[0]  = '{1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 15'h0000};
      tbl[1]  = '{1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 15'h0000};
      tbl[2]  = '{1'b1, 1'b0, 14'h0000, 2'd1, 1'b0, 15'h0000};
      tbl[3]  = '{1'b1, 1'b0, 14'h0000, 2'd1, 1'b0, 15'h0000};
      tbl[4]  = '{1'b1, 1'b0, 14'h0000, 2'd2, 1'b1, 15'h0000};
      tbl[5]  = '{1'b1, 1'b1, 14'h1234, 2'd2, 1'b0, 15'h5234};
      tbl[6]  = '{1'b1, 1'b1, 14'h0001, 2'd2, 1'b0, 15'h5234};
      tbl[7]  = '{1'b1, 1'b1, 14'h0001, 2'd2, 1'b0, 15'h5234};
      tbl[8]  = '{1'b1, 1'b1, 14'h0001, 2'd2, 1'b0, 15'h5234};
      tbl[9]  = '{1'b1, 1'b1, 14'h0001, 2'd2, 1'b1, 15'h5234};
      tbl[10] = '{1'b1, 1'b1, 14'h0001, 2'd2, 1'b0, 15'h0001};
      tbl[11] = '{1'b1, 1'b0, 14'h0000, 2'd2, 1'b0, 15'h0001};

      rst      = 1'b1;
      dir_in   = 1'b0;
      pad_y    = 15'h0000;
      tx_data  = 14'h0000;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      step();
      step();
      check("rst_pad_a", 32'(pad_a), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_overflow", 32'(rx_overflow), 32'd0);
      check("rst_state", 32'(link_state), 32'd0);
      rst = 1'b0;

      // Turnaround into TX and two words with hold spacing.
      for (int i = 0; i < 12; i++) begin
         dir_in   = tbl[i].dir;
         tx_valid = tbl[i].vld;
         tx_data  = tbl[i].dat;
         step();
         check($sformatf("tbl%0d_state", i), 32'(link_state), 32'(tbl[i].st));
         check($sformatf("tbl%0d_tx_ready", i), 32'(tx_ready), 32'(tbl[i].rdy));
         check($sformatf("tbl%0d_pad_a", i), 32'(pad_a), 32'(tbl[i].pad));
      end
      check("tbl_rx_valid", 32'(rx_valid), 32'd0);

      // Direction drop while ready: ready falls within 3 cycles, pad_a holds, toggle continues.
      wait_rdy("t4_ready_before_flip");
      dir_in = 1'b0;
      repeat (3) step();
      check("t4_tx_ready_dropped", 32'(tx_ready), 32'd0);
      check("t4_state_turn", 32'(link_state), 32'd1);
      wait_state(2'd0, "t4_reach_rx");
      check("t4_pad_a_held", 32'(pad_a), 32'h0001);
      dir_in = 1'b1;
      wait_state(2'd2, "t4_back_tx");
      wait_rdy("t4_ready_again");
      tx_valid = 1'b1;
      tx_data  = 14'h0055;
      step();
      tx_valid = 1'b0;
      check("t4_toggle_continues", 32'(pad_a), 32'h4055);

      // Enter RX with a stale word already on the bus.
      hold_bus(15'h4ABC, 4);
      dir_in = 1'b0;
      wait_state(2'd0, "t5_reach_rx");
      repeat (8) step();
      check("t5_stale_ignored", 32'(rx_valid), 32'd0);
      hold_bus(15'h0ABC, 6);
      pop_check(14'h0ABC);
      check("t5_empty", 32'(rx_valid), 32'd0);

      // Stepped words with minimum-latency check and a one-cycle glitch.
      pad_y = 15'h4005;
      repeat (3) step();
      check("t2_lat3_not_valid", 32'(rx_valid), 32'd0);
      step();
      check("t2_lat4_valid", 32'(rx_valid), 32'd1);
      check("t2_lat4_data", 32'(rx_data), 32'h0005);
      repeat (2) step();
      hold_bus(15'h0007, 6);
      hold_bus(15'h7FFF, 1);
      hold_bus(15'h4009, 6);
      pop_check(14'h0005);
      pop_check(14'h0007);
      pop_check(14'h0009);
      check("t2_no_glitch_word", 32'(rx_valid), 32'd0);

      // Five words into a four-entry FIFO with no pops.
      hold_bus(15'h0011, 6);
      hold_bus(15'h4022, 6);
      hold_bus(15'h0033, 6);
      hold_bus(15'h4044, 6);
      check("t3_no_overflow_yet", 32'(rx_overflow), 32'd0);
      hold_bus(15'h0055, 6);
      check("t3_overflow_set", 32'(rx_overflow), 32'd1);
      repeat (4) step();
      check("t3_overflow_sticky", 32'(rx_overflow), 32'd1);
      pop_check(14'h0011);
      pop_check(14'h0022);
      pop_check(14'h0033);
      pop_check(14'h0044);
      check("t3_drained", 32'(rx_valid), 32'd0);
      check("t3_overflow_after_drain", 32'(rx_overflow), 32'd1);

      // Reset with two FIFO words held and TX mid-hold.
      hold_bus(15'h4066, 6);
      hold_bus(15'h0077, 6);
      dir_in = 1'b1;
      wait_state(2'd2, "t6_reach_tx");
      wait_rdy("t6_ready");
      tx_valid = 1'b1;
      tx_data  = 14'h0123;
      step();
      tx_valid = 1'b0;
      check("t6_pad_a_sent", 32'(pad_a), 32'h0123);
      step();
      check("t6_mid_hold", 32'(tx_ready), 32'd0);
      check("t6_fifo_kept", 32'(rx_valid), 32'd1);
      check("t6_fifo_head", 32'(rx_data), 32'h0066);
      rst = 1'b1;
      step();
      check("t6_rx_valid", 32'(rx_valid), 32'd0);
      check("t6_rx_data", 32'(rx_data), 32'd0);
      check("t6_pad_a", 32'(pad_a), 32'd0);
      check("t6_state", 32'(link_state), 32'd0);
      check("t6_overflow", 32'(rx_overflow), 32'd0);
      check("t6_tx_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
